// File: rtl/psum_exch_pkg.sv
// Shared constants and helpers for the partial-sum exchange hub.
package psum_exch_pkg;

  localparam logic MODE_RING   = 1'b0;
  localparam logic MODE_ALLRED = 1'b1;

  localparam int unsigned DEFAULT_BW    = 24;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Pointer width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered empty/full and a combinational head.
module sync_fifo
  import psum_exch_pkg::*;
#(
  parameter int unsigned BW    = DEFAULT_BW,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [BW-1:0] in,
  output logic [BW-1:0] out,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  always_comb begin
    pop     = rd && !empty;
    push    = wr && (!full || pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      empty   <= (count_d == '0);
      full    <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= in;
  end

  assign out = mem[rptr_q];

endmodule

// File: rtl/psum_exchange_hub.sv
// Per-core partial-sum FIFOs with ring or all-reduce exchange on read.
// Optional PSUM_EXCH_SAT_EN clamps all-reduce results to the BW range and adds sat_flag.
module psum_exchange_hub
  import psum_exch_pkg::*;
#(
  parameter int unsigned NCORE = 2,
  parameter int unsigned BW    = DEFAULT_BW,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned LOGN = $clog2(NCORE),
  localparam int unsigned OBW  = BW + LOGN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCORE*BW-1:0]  sum_in,
  input  logic                 wr,
  input  logic                 rd,
  input  logic                 mode,
  output logic [NCORE*OBW-1:0] sum_out,
  output logic                 out_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf_err,
  output logic                 unf_err
`ifdef PSUM_EXCH_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  logic [BW-1:0]         head [NCORE];
  logic [NCORE-1:0]      ch_empty, ch_full;
  logic signed [OBW-1:0] ext  [NCORE];
  logic signed [OBW-1:0] res  [NCORE];
  logic signed [OBW-1:0] total;
  logic [NCORE*OBW-1:0]  sum_out_d;
  logic                  pop;
  logic                  sat_hit;

  for (genvar i = 0; i < NCORE; i++) begin : g_ch
    sync_fifo #(
      .BW    (BW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (wr),
      .rd    (rd),
      .in    (sum_in[i*BW +: BW]),
      .out   (head[i]),
      .empty (ch_empty[i]),
      .full  (ch_full[i])
    );
  end

  assign empty = |ch_empty;
  assign full  = |ch_full;
  assign pop   = rd && !empty;

  // All-reduce as total minus own head: the true result fits OBW, so the
  // modular subtraction is exact.
  always_comb begin
    total     = '0;
    sat_hit   = 1'b0;
    sum_out_d = '0;
    for (int i = 0; i < NCORE; i++) begin
      ext[i] = {{LOGN{head[i][BW-1]}}, head[i]};
      total  = total + ext[i];
    end
    for (int i = 0; i < NCORE; i++) begin
      if (mode == MODE_ALLRED) begin
        res[i] = total - ext[i];
`ifdef PSUM_EXCH_SAT_EN
        if (res[i] > $signed({{(LOGN+1){1'b0}}, {(BW-1){1'b1}}})) begin
          res[i]  = {{(LOGN+1){1'b0}}, {(BW-1){1'b1}}};
          sat_hit = 1'b1;
        end else if (res[i] < $signed({{(LOGN+1){1'b1}}, {(BW-1){1'b0}}})) begin
          res[i]  = {{(LOGN+1){1'b1}}, {(BW-1){1'b0}}};
          sat_hit = 1'b1;
        end
`endif
      end else begin
        res[i] = ext[(i + 1) % NCORE];
      end
      sum_out_d[i*OBW +: OBW] = res[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_out   <= '0;
      out_valid <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
`ifdef PSUM_EXCH_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      if (pop) sum_out <= sum_out_d;
      out_valid <= pop;
      ovf_err   <= ovf_err | (wr && full && !rd);
      unf_err   <= unf_err | (rd && empty);
`ifdef PSUM_EXCH_SAT_EN
      sat_flag  <= sat_flag | (pop && sat_hit);
`endif
    end
  end

endmodule

// File: tb/tb_psum_exchange_hub.sv
// Directed bench for psum_exchange_hub: NCORE=2 and NCORE=4 instances.
module tb_psum_exchange_hub;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // NCORE=2 instance, OBW=25
  logic [47:0] sum_in2 = '0;
  logic [49:0] sum_out2;
  logic wr2 = 1'b0, rd2 = 1'b0, mode2 = 1'b0;
  logic valid2, empty2, full2, ovf2, unf2;
  // NCORE=4 instance, OBW=26
  logic [95:0]  sum_in4 = '0;
  logic [103:0] sum_out4;
  logic wr4 = 1'b0, rd4 = 1'b0, mode4 = 1'b0;
  logic valid4, empty4, full4, ovf4, unf4;
`ifdef PSUM_EXCH_SAT_EN
  logic sat2, sat4;
`endif

  psum_exchange_hub #(.NCORE(2), .BW(24), .DEPTH(8)) u_hub2 (
    .clk       (clk),
    .reset     (reset),
    .sum_in    (sum_in2),
    .wr        (wr2),
    .rd        (rd2),
    .mode      (mode2),
    .sum_out   (sum_out2),
    .out_valid (valid2),
    .empty     (empty2),
    .full      (full2),
    .ovf_err   (ovf2),
    .unf_err   (unf2)
`ifdef PSUM_EXCH_SAT_EN
    ,
    .sat_flag  (sat2)
`endif
  );

  psum_exchange_hub #(.NCORE(4), .BW(24), .DEPTH(8)) u_hub4 (
    .clk       (clk),
    .reset     (reset),
    .sum_in    (sum_in4),
    .wr        (wr4),
    .rd        (rd4),
    .mode      (mode4),
    .sum_out   (sum_out4),
    .out_valid (valid4),
    .empty     (empty4),
    .full      (full4),
    .ovf_err   (ovf4),
    .unf_err   (unf4)
`ifdef PSUM_EXCH_SAT_EN
    ,
    .sat_flag  (sat4)
`endif
  );

  function automatic logic signed [24:0] o2(input int i);
    return sum_out2[i*25 +: 25];
  endfunction

  function automatic logic signed [25:0] o4(input int i);
    return sum_out4[i*26 +: 26];
  endfunction

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic cyc2(input logic w, input logic r, input logic m,
                      input logic signed [23:0] c1, input logic signed [23:0] c0);
    wr2 = w; rd2 = r; mode2 = m; sum_in2 = {c1, c0};
    @(negedge clk);
    wr2 = 1'b0; rd2 = 1'b0;
  endtask

  task automatic cyc4(input logic w, input logic r, input logic m,
                      input logic signed [23:0] c3, input logic signed [23:0] c2,
                      input logic signed [23:0] c1, input logic signed [23:0] c0);
    wr4 = w; rd4 = r; mode4 = m; sum_in4 = {c3, c2, c1, c0};
    @(negedge clk);
    wr4 = 1'b0; rd4 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (sum_out2 !== '0) begin errors++; $display("FAIL rst_sum_out got %h want 0", sum_out2); end
    vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid2); end
    vectors++; if (empty2 !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty2); end
    vectors++; if (full2 !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full2); end
    vectors++; if (ovf2 !== 1'b0 || unf2 !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b want 00", ovf2, unf2); end
    vectors++; if (empty4 !== 1'b1 || sum_out4 !== '0) begin errors++; $display("FAIL rst4 got empty=%b out=%h want 1/0", empty4, sum_out4); end
  endtask

  task automatic test_underflow();
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (unf2 !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", unf2); end
    vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL unf_valid got %b want 0", valid2); end
    vectors++; if (sum_out2 !== '0) begin errors++; $display("FAIL unf_sum_out got %h want 0", sum_out2); end
    cyc2(1'b1, 1'b0, 1'b0, 24'sd7, 24'sd3);
    vectors++; if (empty2 !== 1'b0) begin errors++; $display("FAIL unf_wr_empty got %b want 0", empty2); end
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (valid2 !== 1'b1 || o2(0) !== 25'sd7 || o2(1) !== 25'sd3)
      begin errors++; $display("FAIL unf_pop got v=%b %0d,%0d want 1 7,3", valid2, o2(0), o2(1)); end
  endtask

  task automatic test_ring();
    do_reset();
    cyc2(1'b1, 1'b0, 1'b0, -24'sd5, 24'sd100);
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (o2(0) !== -25'sd5) begin errors++; $display("FAIL ring_core0 got %0d want -5", o2(0)); end
    vectors++; if (o2(1) !== 25'sd100) begin errors++; $display("FAIL ring_core1 got %0d want 100", o2(1)); end
    vectors++; if (valid2 !== 1'b1) begin errors++; $display("FAIL ring_valid got %b want 1", valid2); end
    cyc2(1'b0, 1'b0, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (valid2 !== 1'b0) begin errors++; $display("FAIL ring_pulse got %b want 0", valid2); end
    vectors++; if (o2(0) !== -25'sd5) begin errors++; $display("FAIL ring_hold got %0d want -5", o2(0)); end
  endtask

  task automatic test_allreduce();
    logic signed [25:0] emax, emin;
`ifdef PSUM_EXCH_SAT_EN
    emax = 26'sd8388607;
    emin = -26'sd8388608;
`else
    emax = 26'sd25165821;
    emin = -26'sd25165824;
`endif
    do_reset();
    cyc4(1'b1, 1'b0, 1'b0, 24'sd4, 24'sd3, -24'sd2, 24'sd10);
    cyc4(1'b0, 1'b1, 1'b1, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    vectors++; if (o4(0) !== 26'sd5 || o4(1) !== 26'sd17 || o4(2) !== 26'sd12 || o4(3) !== 26'sd11 || valid4 !== 1'b1)
      begin errors++; $display("FAIL allred got %0d,%0d,%0d,%0d v=%b want 5,17,12,11 v=1", o4(0), o4(1), o4(2), o4(3), valid4); end
    cyc4(1'b1, 1'b0, 1'b1, 24'sd4, 24'sd3, -24'sd2, 24'sd10);
    cyc4(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    vectors++; if (o4(0) !== -26'sd2 || o4(1) !== 26'sd3 || o4(2) !== 26'sd4 || o4(3) !== 26'sd10)
      begin errors++; $display("FAIL ring4 got %0d,%0d,%0d,%0d want -2,3,4,10", o4(0), o4(1), o4(2), o4(3)); end
`ifdef PSUM_EXCH_SAT_EN
    vectors++; if (sat4 !== 1'b0) begin errors++; $display("FAIL sat_before got %b want 0", sat4); end
`endif
    cyc4(1'b1, 1'b0, 1'b0, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF);
    cyc4(1'b0, 1'b1, 1'b1, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    vectors++; if (o4(0) !== emax || o4(3) !== emax)
      begin errors++; $display("FAIL allred_max got %0d,%0d want %0d", o4(0), o4(3), emax); end
`ifdef PSUM_EXCH_SAT_EN
    vectors++; if (sat4 !== 1'b1) begin errors++; $display("FAIL sat_after got %b want 1", sat4); end
`endif
    cyc4(1'b1, 1'b0, 1'b0, 24'sh800000, 24'sh800000, 24'sh800000, 24'sh800000);
    cyc4(1'b0, 1'b1, 1'b1, 24'sd0, 24'sd0, 24'sd0, 24'sd0);
    vectors++; if (o4(1) !== emin || o4(2) !== emin)
      begin errors++; $display("FAIL allred_min got %0d,%0d want %0d", o4(1), o4(2), emin); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      cyc2(1'b1, 1'b0, 1'b0, 24'(k + 100), 24'(k));
      if (k == 7) begin
        vectors++; if (full2 !== 1'b0) begin errors++; $display("FAIL full_at7 got %b want 0", full2); end
      end
    end
    vectors++; if (full2 !== 1'b1 || ovf2 !== 1'b0) begin errors++; $display("FAIL full_at8 got full=%b ovf=%b want 1/0", full2, ovf2); end
    cyc2(1'b1, 1'b0, 1'b0, 24'sd99, 24'sd99);
    vectors++; if (ovf2 !== 1'b1 || full2 !== 1'b1) begin errors++; $display("FAIL ovf got ovf=%b full=%b want 1/1", ovf2, full2); end
    cyc2(1'b1, 1'b1, 1'b0, 24'sd109, 24'sd9);
    vectors++; if (valid2 !== 1'b1 || o2(0) !== 25'sd101 || o2(1) !== 25'sd1 || full2 !== 1'b1)
      begin errors++; $display("FAIL wr_rd_full got v=%b %0d,%0d full=%b want 1 101,1 1", valid2, o2(0), o2(1), full2); end
    for (int k = 2; k <= 9; k++) begin
      cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
      vectors++; if (valid2 !== 1'b1 || o2(1) !== 25'(k) || o2(0) !== 25'(k + 100))
        begin errors++; $display("FAIL drain%0d got v=%b %0d,%0d want 1 %0d,%0d", k, valid2, o2(0), o2(1), k + 100, k); end
    end
    vectors++; if (empty2 !== 1'b1 || unf2 !== 1'b0) begin errors++; $display("FAIL drain_end got empty=%b unf=%b want 1/0", empty2, unf2); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 1; k <= 5; k++) cyc2(1'b1, 1'b0, 1'b0, 24'(k + 100), 24'(k));
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (o2(1) !== 25'sd2 || valid2 !== 1'b1) begin errors++; $display("FAIL mid_pop got %0d v=%b want 2 v=1", o2(1), valid2); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (valid2 !== 1'b0 || sum_out2 !== '0) begin errors++; $display("FAIL mid_rst_out got v=%b out=%h want 0/0", valid2, sum_out2); end
    vectors++; if (empty2 !== 1'b1 || full2 !== 1'b0 || ovf2 !== 1'b0 || unf2 !== 1'b0)
      begin errors++; $display("FAIL mid_rst_flags got e=%b f=%b o=%b u=%b want 1000", empty2, full2, ovf2, unf2); end
    @(negedge clk);
    reset = 1'b1;
    cyc2(1'b0, 1'b1, 1'b0, 24'sd0, 24'sd0);
    vectors++; if (unf2 !== 1'b1 || valid2 !== 1'b0) begin errors++; $display("FAIL mid_rst_rd got unf=%b v=%b want 1/0", unf2, valid2); end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_ring();
    test_allreduce();
    test_full();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/psum_exchange_hub.md
Name: psum_exchange_hub

Overview:
- Parametrised successor to the two-core, fixed depth-8 partial-sum FIFO pair at the fullchip level.
- Accepts one signed partial sum per core per write strobe and buffers each core's stream in its own FIFO.
- On a read strobe it pops all FIFOs together. It returns to every core either its ring neighbour's sum or the sum of all other cores' values (all-reduce), plus valid and error status.
- Sits between NCORE core instances and is driven by the instruction-decoded wr/rd bits.

Parameters:
- NCORE, 2, number of cores/channels (>=2).
- BW, 24, width of each signed input partial sum (bw_psum+4).
- DEPTH, 8, entries per channel FIFO (power of two, >=2).
- LOGN, $clog2(NCORE), localparam: growth bits for all-reduce.
- OBW, BW+LOGN, localparam: width of each output sum.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- sum_in  input  NCORE*BW  packed per-core signed sums; core i at [i*BW +: BW].
- wr  input  1  push sum_in[i] into FIFO i, all channels together.
- rd  input  1  pop all FIFOs and produce outputs.
- mode  input  1  0 = ring (core i gets core (i+1)%NCORE), 1 = all-reduce (core i gets the sum of all j != i).
- sum_out  output  NCORE*OBW  packed per-core signed results, sign-extended.
- out_valid  output  1  one-cycle pulse, sum_out updated.
- empty  output  1  any FIFO empty.
- full  output  1  any FIFO full.
- ovf_err  output  1  sticky: write attempted while full.
- unf_err  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset=0, async):
  - All FIFO pointers and counts go to 0.
  - sum_out=0, out_valid=0, empty=1, full=0, ovf_err=0, unf_err=0.
  - Reset mid-operation discards all buffered data.
- FIFOs:
  - All channels share the same wr/rd, so their occupancy is always identical.
  - empty and full are registered from the count: count==0 and count==DEPTH respectively.
  - Pointers wrap modulo DEPTH.
  - A write at cycle t makes the data visible at the head, and deasserts empty, at t+1.
- Write rules:
  - wr=1 and not full: push.
  - wr=1 and full, rd=0: the word is dropped and ovf_err is set.
  - wr=1, rd=1 and full: pop and push both occur, count is unchanged, no error.
- Read rules:
  - rd=1 and not empty: pop all heads.
  - rd=1 and empty: no pop, sum_out holds its value, out_valid stays 0, unf_err is set.
  - wr=1, rd=1 and empty: push only, and unf_err is set. There is no write-through bypass.
- Output latency:
  - rd accepted at cycle t gives the registered sum_out and out_valid=1 at t+1.
  - out_valid is a single-cycle pulse; back-to-back reads give back-to-back valid pulses.
  - mode is sampled in the same cycle as rd.
- Arithmetic:
  - Ring mode: sign-extend the neighbour's head to OBW.
  - All-reduce mode: signed sum of NCORE-1 heads at OBW width, which cannot overflow.
  - NCORE=2 in either mode reproduces the legacy swap (core0 gets core1, core1 gets core0).
- Error flags: ovf_err and unf_err clear only on reset.

Optional Feature:
- Macro: PSUM_EXCH_SAT_EN.
- When defined, each all-reduce result is clamped to the signed BW range [-2^(BW-1), 2^(BW-1)-1] before sign-extension to OBW. A sticky sat_flag output is added, set on any clamp.
- When undefined: full OBW results, and there is no sat_flag port.
- Ring mode is identical either way.

Decomposition:
- Package psum_exch_pkg:
  - MODE_RING=1'b0 and MODE_ALLRED=1'b1 constants.
  - Default BW/DEPTH localparams.
  - Function clog2_min1.
- Sub-module sync_fifo (params BW, DEPTH; ports clk, reset, wr, rd, in, out, empty, full).
  - Instantiated NCORE times via generate.
  - Registered empty/full; head visible combinationally at out.
- The hub holds the error flags, the reduce/ring mux, and the output register.

Test Plan:
- Ring swap: NCORE=2, mode=0, write {core1=-5, core0=100}, then rd. At the next cycle sum_out core0=-5, core1=100, out_valid=1 for exactly one cycle.
- All-reduce: NCORE=4, mode=1, inputs {core3..0} = {4, 3, -2, 10}, then rd. Required outputs:
  - core0=5, core1=17, core2=12, core3=11.
  - Also drive all cores with 0x7FFFFF and check core0=3*8388607 with no wrap.
- Full/overflow: write 8 words (full=1 after the 8th), then a 9th wr alone. The word is dropped and ovf_err=1. Then wr+rd together while full: count stays 8, no new error, and the FIFO order is preserved.
- Underflow: rd on empty right after reset. unf_err=1, out_valid=0, sum_out stays 0. A following wr clears empty one cycle later.
- Reset mid-stream: push 5 words, pop 2, then pulse reset low asynchronously between clock edges. All outputs return to their reset values immediately, and the next rd flags unf_err.
- PSUM_EXCH_SAT_EN: NCORE=4, all-reduce on all heads = 0x7FFFFF. Output clamps to 0x7FFFFF sign-extended and sat_flag=1. Without the macro the output is 0x17FFFFD.
